// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: latches operands, holds start,
// stalls the pipe, and owns the HI/LO registers. Define HILO_BYPASS_EN to forward same-cycle HI/LO writes.
module div_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_div_valid_in,
    input  logic                  ex_div_signed_in,
    input  logic [DATA_W-1:0]     ex_op1_in,
    input  logic [DATA_W-1:0]     ex_op2_in,
    input  logic                  flush_in,
    input  logic                  mthi_we_in,
    input  logic                  mtlo_we_in,
    input  logic [DATA_W-1:0]     mt_data_in,
    input  logic                  div_ready_in,
    input  logic [2*DATA_W-1:0]   div_res_in,
    output logic                  div_start_out,
    output logic                  div_cancel_out,
    output logic                  div_signed_out,
    output logic [DATA_W-1:0]     div_dived_out,
    output logic [DATA_W-1:0]     div_div_out,
    output logic                  stall_req_out,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic [1:0]            dbg_state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start;
    logic                w_start_nxt;
    logic                r_cancel;
    logic                w_cancel_nxt;
    logic                r_signed;
    logic                w_signed_nxt;
    logic [DATA_W-1:0]   r_dived;
    logic [DATA_W-1:0]   w_dived_nxt;
    logic [DATA_W-1:0]   r_div;
    logic [DATA_W-1:0]   w_div_nxt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   w_hi_nxt;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   w_lo_nxt;
    logic                w_stall;
    logic                w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_start  <= 1'b0;
            r_cancel <= 1'b0;
            r_signed <= 1'b0;
            r_dived  <= '0;
            r_div    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            r_cancel <= w_cancel_nxt;
            r_signed <= w_signed_nxt;
            r_dived  <= w_dived_nxt;
            r_div    <= w_div_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_nxt  = r_start;
        w_cancel_nxt = 1'b0;
        w_signed_nxt = r_signed;
        w_dived_nxt  = r_dived;
        w_div_nxt    = r_div;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_stall      = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ex_div_valid_in && !flush_in) begin
                    w_dived_nxt  = ex_op1_in;
                    w_div_nxt    = ex_op2_in;
                    w_signed_nxt = ex_div_signed_in;
                    w_start_nxt  = 1'b1;
                    w_stall      = 1'b1;
                    w_state_nxt  = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                // Flush wins over a same-cycle result: the killed div must not touch HI/LO.
                if (flush_in) begin
                    w_cancel_nxt = 1'b1;
                    w_start_nxt  = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (div_ready_in) begin
                    w_capture   = 1'b1;
                    w_stall     = 1'b0;
                    w_hi_nxt    = div_res_in[2*DATA_W-1:DATA_W];
                    w_lo_nxt    = div_res_in[DATA_W-1:0];
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A div arriving here waits one cycle so the divider sees start low first.
                w_start_nxt = 1'b0;
                w_stall     = ex_div_valid_in;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_start_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!w_capture && !flush_in) begin
            if (mthi_we_in) w_hi_nxt = mt_data_in;
            if (mtlo_we_in) w_lo_nxt = mt_data_in;
        end
    end

    assign div_start_out  = r_start;
    assign div_cancel_out = r_cancel;
    assign div_signed_out = r_signed;
    assign div_dived_out  = r_dived;
    assign div_div_out    = r_div;
    assign stall_req_out  = w_stall;
    assign dbg_state_out  = r_state;

`ifdef HILO_BYPASS_EN
    assign hi_out = w_hi_nxt;
    assign lo_out = w_lo_nxt;
`else
    assign hi_out = r_hi;
    assign lo_out = r_lo;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: a scripted divider model drives ready/result,
// and expected HI/LO values are queued at issue and popped at completion.
module tb_div_issue_ctrl;

    localparam int DW = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic            clk;
    logic            rst_n;
    logic            ex_div_valid_in;
    logic            ex_div_signed_in;
    logic [DW-1:0]   ex_op1_in;
    logic [DW-1:0]   ex_op2_in;
    logic            flush_in;
    logic            mthi_we_in;
    logic            mtlo_we_in;
    logic [DW-1:0]   mt_data_in;
    logic            div_ready_in;
    logic [2*DW-1:0] div_res_in;
    logic            div_start_out;
    logic            div_cancel_out;
    logic            div_signed_out;
    logic [DW-1:0]   div_dived_out;
    logic [DW-1:0]   div_div_out;
    logic            stall_req_out;
    logic [DW-1:0]   hi_out;
    logic [DW-1:0]   lo_out;
    logic [1:0]      dbg_state_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_start_edges = 0;
    logic prev_start = 1'b0;
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0] model_hi = '0;
    logic [DW-1:0] model_lo = '0;

    div_issue_ctrl #(.DATA_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_div_valid_in  (ex_div_valid_in),
        .ex_div_signed_in (ex_div_signed_in),
        .ex_op1_in        (ex_op1_in),
        .ex_op2_in        (ex_op2_in),
        .flush_in         (flush_in),
        .mthi_we_in       (mthi_we_in),
        .mtlo_we_in       (mtlo_we_in),
        .mt_data_in       (mt_data_in),
        .div_ready_in     (div_ready_in),
        .div_res_in       (div_res_in),
        .div_start_out    (div_start_out),
        .div_cancel_out   (div_cancel_out),
        .div_signed_out   (div_signed_out),
        .div_dived_out    (div_dived_out),
        .div_div_out      (div_div_out),
        .stall_req_out    (stall_req_out),
        .hi_out           (hi_out),
        .lo_out           (lo_out),
        .dbg_state_out    (dbg_state_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start_out && !prev_start) n_start_edges++;
        prev_start = div_start_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Issue one div from IDLE; the divider model raises ready in BUSY cycle 'lat'
    // unless a flush is injected at BUSY cycle 'flush_at' (0 = none).
    task automatic issue_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input int lat, input logic [DW-1:0] rhi, input logic [DW-1:0] rlo,
                             input int flush_at, input logic clash);
        int stall_cnt;
        @(negedge clk);
        ex_div_valid_in  = 1'b1;
        ex_div_signed_in = sgn;
        ex_op1_in        = a;
        ex_op2_in        = b;
        #1;
        check("issue_stall", stall_req_out, 1);
        stall_cnt = 1;
        @(posedge clk);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            div_res_in = {rhi, rlo};
            if (n == flush_at) begin
                flush_in = 1'b1;
                div_ready_in = 1'b0;
            end else begin
                div_ready_in = (n == lat);
                if (clash && n == lat) begin
                    mthi_we_in = 1'b1;
                    mtlo_we_in = 1'b1;
                    mt_data_in = 32'h5555_5555;
                end
            end
            #1;
            if (n == 1) begin
                check("busy_state", dbg_state_out, ST_BUSY);
                check("busy_start", div_start_out, 1);
                check("busy_dived", div_dived_out, a);
                check("busy_div", div_div_out, b);
                check("busy_cancel", div_cancel_out, 0);
            end
            check("busy_signed", div_signed_out, sgn);
            if (stall_req_out) stall_cnt++;
            @(posedge clk);
            if (n == flush_at) break;
        end
        #1;
        flush_in = 1'b0;
        div_ready_in = 1'b0;
        ex_div_valid_in = 1'b0;
        mthi_we_in = 1'b0;
        mtlo_we_in = 1'b0;
        if (flush_at == 0) begin
            check("stall_cycles", stall_cnt, lat);
            exp_q.push_back({rhi, rlo});
            model_hi = rhi;
            model_lo = rlo;
        end
    endtask

    // DONE-cycle checks; optionally present the next div while still in DONE.
    task automatic finish_div(input logic nv, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] e;
        @(negedge clk);
        ex_div_valid_in  = nv;
        ex_div_signed_in = 1'b0;
        ex_op1_in        = a;
        ex_op2_in        = b;
        #1;
        e = exp_q.pop_front();
        check("done_state", dbg_state_out, ST_DONE);
        check("done_start", div_start_out, 0);
        check("done_stall", stall_req_out, nv);
        check("done_hi", hi_out, e[2*DW-1:DW]);
        check("done_lo", lo_out, e[DW-1:0]);
    endtask

    task automatic mt_write(input logic we_hi, input logic we_lo, input logic [DW-1:0] d, input logic fl);
        logic [DW-1:0] eh;
        logic [DW-1:0] el;
        eh = (we_hi && !fl) ? d : model_hi;
        el = (we_lo && !fl) ? d : model_lo;
        @(negedge clk);
        mthi_we_in = we_hi;
        mtlo_we_in = we_lo;
        mt_data_in = d;
        flush_in   = fl;
        #1;
`ifdef HILO_BYPASS_EN
        check("mt_bypass_hi", hi_out, eh);
        check("mt_bypass_lo", lo_out, el);
`else
        check("mt_nobypass_hi", hi_out, model_hi);
        check("mt_nobypass_lo", lo_out, model_lo);
`endif
        @(posedge clk);
        #1;
        mthi_we_in = 1'b0;
        mtlo_we_in = 1'b0;
        flush_in   = 1'b0;
        model_hi = eh;
        model_lo = el;
        @(negedge clk);
        check("mt_hi", hi_out, eh);
        check("mt_lo", lo_out, el);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        ex_div_valid_in = 1'b0;
        ex_div_signed_in = 1'b0;
        ex_op1_in = '0;
        ex_op2_in = '0;
        flush_in = 1'b0;
        mthi_we_in = 1'b0;
        mtlo_we_in = 1'b0;
        mt_data_in = '0;
        div_ready_in = 1'b0;
        div_res_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", dbg_state_out, ST_IDLE);
        check("rst_start", div_start_out, 0);
        check("rst_cancel", div_cancel_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_stall", stall_req_out, 0);

        // DIVU 100/7 with a 34-cycle divider; DIV -7/2 with an MT write clashing on ready.
        issue_div(1'b0, 32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E, 0, 1'b0);
        finish_div(1'b0, '0, '0);
        issue_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1);
        finish_div(1'b0, '0, '0);
        @(negedge clk);
        check("idle_after_done", dbg_state_out, ST_IDLE);

        mt_write(1'b1, 1'b0, 32'h1234_5678, 1'b0);
        mt_write(1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        mt_write(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        mt_write(1'b1, 1'b0, 32'hAAAA_0000, 1'b0);
        mt_write(1'b0, 1'b1, 32'h0000_BBBB, 1'b0);

        // Flush on BUSY cycle 10: one-cycle cancel, HI/LO untouched.
        issue_div(1'b0, 32'd50, 32'd5, 34, 32'h1111_1111, 32'h2222_2222, 10, 1'b0);
        @(negedge clk);
        check("flush_cancel", div_cancel_out, 1);
        check("flush_start", div_start_out, 0);
        check("flush_state", dbg_state_out, ST_IDLE);
        check("flush_hi", hi_out, 32'hAAAA_0000);
        check("flush_lo", lo_out, 32'h0000_BBBB);
        @(negedge clk);
        check("cancel_pulse_end", div_cancel_out, 0);

        // Back-to-back DIVU 9/3 then 8/4; the second waits through DONE.
        base = n_start_edges;
        issue_div(1'b0, 32'd9, 32'd3, 3, 32'd0, 32'd3, 0, 1'b0);
        finish_div(1'b1, 32'd8, 32'd4);
        issue_div(1'b0, 32'd8, 32'd4, 2, 32'd0, 32'd2, 0, 1'b0);
        finish_div(1'b0, '0, '0);
        @(negedge clk);
        check("b2b_start_edges", n_start_edges - base, 2);
        check("b2b_hi", hi_out, 0);
        check("b2b_lo", lo_out, 2);

        // Reset mid-BUSY, then DIVU 6/3.
        @(negedge clk);
        ex_div_valid_in = 1'b1;
        ex_op1_in = 32'd77;
        ex_op2_in = 32'd11;
        repeat (5) @(negedge clk);
        check("pre_rst_start", div_start_out, 1);
        rst_n = 1'b0;
        #1;
        check("arst_start", div_start_out, 0);
        check("arst_cancel", div_cancel_out, 0);
        check("arst_dived", div_dived_out, 0);
        check("arst_div", div_div_out, 0);
        check("arst_state", dbg_state_out, ST_IDLE);
        check("arst_hilo", {hi_out, lo_out}, 0);
        ex_div_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_hi = '0;
        model_lo = '0;
        issue_div(1'b0, 32'd6, 32'd3, 4, 32'd0, 32'd2, 0, 1'b0);
        finish_div(1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
